// File: rtl/exe_mc_stage_if.sv
// Bundle of the EX-stage ports: decoded instruction in, forwarding inputs,
// stall/busy status and the registered EX/MEM pipeline outputs.
interface exe_mc_stage_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
);
  logic               Valid_IN;
  logic [31:0]        Instr1_IN;
  logic [31:0]        Instr1_PC_IN;
  logic [DATA_W-1:0]  OperandA1_IN;
  logic [DATA_W-1:0]  OperandB1_IN;
  logic [DATA_W-1:0]  MemWriteData1_IN;
  logic [REG_W-1:0]   WriteRegister1_IN;
  logic               RegWrite1_IN;
  logic               MemRead1_IN;
  logic               MemWrite1_IN;
  logic [5:0]         ALU_Control1_IN;
  logic [SHAMT_W-1:0] ShiftAmount1_IN;
  logic [1:0]         ForwardA;
  logic [1:0]         ForwardB;
  logic [DATA_W-1:0]  RegWrite_EXEMEM;
  logic [DATA_W-1:0]  RegWrite_MEMWB;

  logic               Stall_OUT;
  logic               Busy_OUT;
  logic               Valid_OUT;
  logic [31:0]        Instr1_OUT;
  logic [31:0]        Instr1_PC_OUT;
  logic [DATA_W-1:0]  ALU_result1_OUT;
  logic [REG_W-1:0]   WriteRegister1_OUT;
  logic [DATA_W-1:0]  MemWriteData1_OUT;
  logic               RegWrite1_OUT;
  logic [5:0]         ALU_Control1_OUT;
  logic               MemRead1_OUT;
  logic               MemWrite1_OUT;

  // Upstream decode / forwarding side drives the *_IN ports.
  modport master (
    output Valid_IN, Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN,
           MemWriteData1_IN, WriteRegister1_IN, RegWrite1_IN, MemRead1_IN,
           MemWrite1_IN, ALU_Control1_IN, ShiftAmount1_IN, ForwardA, ForwardB,
           RegWrite_EXEMEM, RegWrite_MEMWB,
    input  Stall_OUT, Busy_OUT, Valid_OUT, Instr1_OUT, Instr1_PC_OUT,
           ALU_result1_OUT, WriteRegister1_OUT, MemWriteData1_OUT,
           RegWrite1_OUT, ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT
  );

  // The EX stage itself.
  modport slave (
    input  Valid_IN, Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN,
           MemWriteData1_IN, WriteRegister1_IN, RegWrite1_IN, MemRead1_IN,
           MemWrite1_IN, ALU_Control1_IN, ShiftAmount1_IN, ForwardA, ForwardB,
           RegWrite_EXEMEM, RegWrite_MEMWB,
    output Stall_OUT, Busy_OUT, Valid_OUT, Instr1_OUT, Instr1_PC_OUT,
           ALU_result1_OUT, WriteRegister1_OUT, MemWriteData1_OUT,
           RegWrite1_OUT, ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT
  );
endinterface

// File: rtl/exe_mc_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, HI/LO registers and a
// one-bit-per-cycle multiply/divide unit, feeding a registered EX/MEM stage.
module exe_mc_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
) (
  input logic           CLK,
  input logic           RESET,
  exe_mc_stage_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [5:0] OP_AND  = 6'h00, OP_OR   = 6'h01, OP_ADD  = 6'h02,
                         OP_SUB  = 6'h06, OP_SLT  = 6'h07, OP_SLL  = 6'h08,
                         OP_SRL  = 6'h09, OP_SRA  = 6'h0A, OP_MFHI = 6'h10,
                         OP_MTHI = 6'h11, OP_MFLO = 6'h12, OP_MTLO = 6'h13;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              reg_write;
    logic [5:0]        alu_ctrl;
    logic              mem_read;
    logic              mem_write;
  } exmem_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [DATA_W-1:0]   r_hi_w, r_lo_w, r_mcand;
  logic                r_is_div, r_neg_q, r_neg_r, r_div_zero;
  exmem_t              r_exmem, w_exmem_nxt;

  logic [DATA_W-1:0]   w_op_a, w_op_b, w_a_mag, w_b_mag, w_result;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [5:0]          w_op;
  logic                w_is_hilo, w_is_iter, w_busy, w_stall, w_accept;
  logic                w_start, w_last, w_signed, w_a_neg, w_b_neg;
  logic [DATA_W:0]     w_mul_sum, w_div_shift;
  logic [DATA_W-1:0]   w_div_sub, w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
  logic                w_div_ge;
  logic [2*DATA_W-1:0] w_prod;

  assign w_op      = bus.ALU_Control1_IN;
  assign w_shamt   = bus.ShiftAmount1_IN;
  assign w_is_hilo = (w_op[5:2] == 4'b0100);   // 10..13
  assign w_is_iter = (w_op[5:2] == 4'b0110);   // 18..1B
  assign w_busy    = (r_state == S_BUSY);
  assign w_stall   = RESET & bus.Valid_IN & w_busy & (w_is_hilo | w_is_iter);
  assign w_accept  = bus.Valid_IN & ~w_stall;
  // Iterative ops are stalled while busy, so any accepted one starts from IDLE.
  assign w_start   = w_accept & w_is_iter;
  assign w_last    = w_busy & (r_cnt == CNT_W'(DATA_W - 1));

  // Operand forwarding; 00 and 11 both take the decoded operand.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_op_a = bus.OperandA1_IN;
    w_op_b = bus.OperandB1_IN;
    if (bus.ForwardA == 2'b01) w_op_a = bus.RegWrite_EXEMEM;
    else if (bus.ForwardA == 2'b10) w_op_a = bus.RegWrite_MEMWB;
    if (bus.ForwardB == 2'b01) w_op_b = bus.RegWrite_EXEMEM;
    else if (bus.ForwardB == 2'b10) w_op_b = bus.RegWrite_MEMWB;
  end

  // Sign handling for the iterative unit: it works on magnitudes.
  assign w_signed = ~w_op[0];
  assign w_a_neg  = w_signed & w_op_a[DATA_W-1];
  assign w_b_neg  = w_signed & w_op_b[DATA_W-1];
  assign w_a_mag  = w_a_neg ? -w_op_a : w_op_a;
  assign w_b_mag  = w_b_neg ? -w_op_b : w_op_b;

  // Single-cycle ALU result; iterative and unknown ops produce zero.
  always_comb begin
    w_result = '0;
    case (w_op)
      OP_AND:  w_result = w_op_a & w_op_b;
      OP_OR:   w_result = w_op_a | w_op_b;
      OP_ADD:  w_result = w_op_a + w_op_b;
      OP_SUB:  w_result = w_op_a - w_op_b;
      OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      OP_SLL:  w_result = w_op_b << w_shamt;
      OP_SRL:  w_result = w_op_b >> w_shamt;
      OP_SRA:  w_result = $signed(w_op_b) >>> w_shamt;
      OP_MFHI: w_result = r_hi;
      OP_MFLO: w_result = r_lo;
      default: w_result = '0;
    endcase
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi_w} + (r_lo_w[0] ? {1'b0, r_mcand} : '0);
    w_div_shift = {r_hi_w, r_lo_w[DATA_W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    w_div_sub   = w_div_shift[DATA_W-1:0] - r_mcand;
    if (r_is_div) begin
      w_step_hi = w_div_ge ? w_div_sub : w_div_shift[DATA_W-1:0];
      w_step_lo = {r_lo_w[DATA_W-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[DATA_W:1];
      w_step_lo = {w_mul_sum[0], r_lo_w[DATA_W-1:1]};
    end
  end

  // Sign fix-up of the last step; divide by zero forces an all-ones quotient.
  always_comb begin
    w_prod   = {w_step_hi, w_step_lo};
    w_prod   = r_neg_q ? -w_prod : w_prod;
    w_fin_hi = w_prod[2*DATA_W-1:DATA_W];
    w_fin_lo = w_prod[DATA_W-1:0];
    if (r_is_div) begin
      w_fin_hi = r_neg_r ? -w_step_hi : w_step_hi;
      w_fin_lo = r_div_zero ? '1 : (r_neg_q ? -w_step_lo : w_step_lo);
    end
  end

  // Multiply/divide state register.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: IDLE until an iterative op is accepted, BUSY for DATA_W cycles.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iterative datapath: load operands on start, one bit per busy cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt      <= '0;
      r_hi_w     <= '0;
      r_lo_w     <= '0;
      r_mcand    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_hi_w     <= '0;
      r_is_div   <= w_op[1];
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_div_zero <= w_op[1] & (w_op_b == '0);
      r_lo_w     <= w_op[1] ? w_a_mag : w_b_mag;
      r_mcand    <= w_op[1] ? w_b_mag : w_a_mag;
    end else if (w_busy) begin
      r_cnt      <= r_cnt + CNT_W'(1);
      r_hi_w     <= w_step_hi;
      r_lo_w     <= w_step_lo;
    end
  end

  // Architectural HI/LO: written by the final iteration or by MTHI/MTLO.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_fin_hi;
      r_lo <= w_fin_lo;
    end else if (w_accept && w_op == OP_MTHI) begin
      r_hi <= w_op_a;
    end else if (w_accept && w_op == OP_MTLO) begin
      r_lo <= w_op_a;
    end
  end

  // EX/MEM contents: the accepted instruction, otherwise an all-zero bubble.
  always_comb begin
    w_exmem_nxt = '0;
    if (w_accept) begin
      w_exmem_nxt.valid     = 1'b1;
      w_exmem_nxt.instr     = bus.Instr1_IN;
      w_exmem_nxt.pc        = bus.Instr1_PC_IN;
      w_exmem_nxt.result    = w_result;
      w_exmem_nxt.wreg      = bus.WriteRegister1_IN;
      w_exmem_nxt.wdata     = bus.MemWriteData1_IN;
      w_exmem_nxt.reg_write = bus.RegWrite1_IN;
      w_exmem_nxt.alu_ctrl  = w_op;
      w_exmem_nxt.mem_read  = bus.MemRead1_IN;
      w_exmem_nxt.mem_write = bus.MemWrite1_IN;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_exmem <= '0;
    else        r_exmem <= w_exmem_nxt;
  end

  assign bus.Stall_OUT          = w_stall;
  assign bus.Busy_OUT           = w_busy;
  assign bus.Valid_OUT          = r_exmem.valid;
  assign bus.Instr1_OUT         = r_exmem.instr;
  assign bus.Instr1_PC_OUT      = r_exmem.pc;
  assign bus.ALU_result1_OUT    = r_exmem.result;
  assign bus.WriteRegister1_OUT = r_exmem.wreg;
  assign bus.MemWriteData1_OUT  = r_exmem.wdata;
  assign bus.RegWrite1_OUT      = r_exmem.reg_write;
  assign bus.ALU_Control1_OUT   = r_exmem.alu_ctrl;
  assign bus.MemRead1_OUT       = r_exmem.mem_read;
  assign bus.MemWrite1_OUT      = r_exmem.mem_write;
endmodule

// File: tb/tb_exe_mc_stage.sv
// Directed bench for exe_mc_stage: a 32-bit instance for most vectors and a
// 16-bit instance for the narrow multiply.
module tb_exe_mc_stage;
  localparam logic [5:0] AND_ = 6'h00, OR_ = 6'h01, ADD = 6'h02, SUB = 6'h06,
                         SLT = 6'h07, SLL = 6'h08, SRL = 6'h09, SRA = 6'h0A,
                         MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13,
                         MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  int   n;

  exe_mc_stage_if #(.DATA_W(32), .SHAMT_W(5), .REG_W(5)) b32 ();
  exe_mc_stage_if #(.DATA_W(16), .SHAMT_W(4), .REG_W(5)) b16 ();

  exe_mc_stage #(.DATA_W(32), .SHAMT_W(5), .REG_W(5)) u_dut32 (
    .CLK(CLK), .RESET(RESET), .bus(b32));
  exe_mc_stage #(.DATA_W(16), .SHAMT_W(4), .REG_W(5)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .bus(b16));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    b32.Valid_IN = 0; b32.Instr1_IN = 0; b32.Instr1_PC_IN = 0;
    b32.OperandA1_IN = 0; b32.OperandB1_IN = 0; b32.MemWriteData1_IN = 0;
    b32.WriteRegister1_IN = 0; b32.RegWrite1_IN = 0; b32.MemRead1_IN = 0;
    b32.MemWrite1_IN = 0; b32.ALU_Control1_IN = 0; b32.ShiftAmount1_IN = 0;
    b32.ForwardA = 0; b32.ForwardB = 0; b32.RegWrite_EXEMEM = 0; b32.RegWrite_MEMWB = 0;
    b16.Valid_IN = 0; b16.Instr1_IN = 0; b16.Instr1_PC_IN = 0;
    b16.OperandA1_IN = 0; b16.OperandB1_IN = 0; b16.MemWriteData1_IN = 0;
    b16.WriteRegister1_IN = 0; b16.RegWrite1_IN = 0; b16.MemRead1_IN = 0;
    b16.MemWrite1_IN = 0; b16.ALU_Control1_IN = 0; b16.ShiftAmount1_IN = 0;
    b16.ForwardA = 0; b16.ForwardB = 0; b16.RegWrite_EXEMEM = 0; b16.RegWrite_MEMWB = 0;
  endtask

  task automatic drv(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [1:0] fa, input logic [1:0] fb);
    b32.Valid_IN = 1; b32.ALU_Control1_IN = op;
    b32.OperandA1_IN = a; b32.OperandB1_IN = b; b32.ShiftAmount1_IN = sh;
    b32.ForwardA = fa; b32.ForwardB = fb;
    b32.RegWrite1_IN = 1; b32.MemRead1_IN = 0; b32.MemWrite1_IN = 0;
    b32.MemWriteData1_IN = 0; b32.WriteRegister1_IN = 5'd3;
    b32.Instr1_IN = 32'h1000_0000 | 32'(op); b32.Instr1_PC_IN = 32'h0000_0400;
  endtask

  // Single-cycle op, result one edge later.
  task automatic alu(input string tag, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    drv(op, a, b, sh, 2'b00, 2'b00);
    cyc();
    check(tag, b32.ALU_result1_OUT, exp);
  endtask

  // Present MFHI/MFLO, ride out any stall (bounded), then check the value.
  task automatic mf_read(input string tag, input logic [5:0] op, input logic [31:0] exp,
                         output int stalls);
    stalls = 0;
    drv(op, 0, 0, 0, 2'b00, 2'b00);
    #1;
    while (b32.Stall_OUT && stalls < 200) begin
      cyc();
      stalls++;
    end
    if (stalls >= 200) check({tag, "_timeout"}, 64'(stalls), 64'd0);
    cyc();
    check(tag, b32.ALU_result1_OUT, exp);
    check({tag, "_valid"}, b32.Valid_OUT, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    idle_all();
    // Instruction presented during reset must not reach the outputs.
    drv(ADD, 1, 1, 0, 2'b00, 2'b00);
    cyc(); cyc();
    check("rst_valid", b32.Valid_OUT, 0);
    check("rst_result", b32.ALU_result1_OUT, 0);
    check("rst_busy", b32.Busy_OUT, 0);
    check("rst_stall", b32.Stall_OUT, 0);
    #2 RESET = 1'b1;

    // Forwarded ADD, first acceptance after reset release.
    drv(ADD, 5, 7, 0, 2'b01, 2'b00);
    b32.RegWrite_EXEMEM = 32'h10;
    #1 check("add_fwd_stall", b32.Stall_OUT, 0);
    cyc();
    check("add_fwd", b32.ALU_result1_OUT, 32'h17);
    check("add_valid", b32.Valid_OUT, 1);
    check("add_pc", b32.Instr1_PC_OUT, 32'h400);
    check("add_wreg", b32.WriteRegister1_OUT, 3);
    check("add_regwrite", b32.RegWrite1_OUT, 1);

    // SUB with B forwarded from MEM/WB, wraps below zero.
    drv(SUB, 3, 99, 0, 2'b00, 2'b10);
    b32.RegWrite_MEMWB = 32'h5;
    cyc();
    check("sub_fwdb", b32.ALU_result1_OUT, 32'hFFFF_FFFE);
    // ForwardA=11 selects the decoded operand.
    drv(ADD, 32'hFFFF_FFFF, 2, 0, 2'b11, 2'b00);
    cyc();
    check("add_wrap_fa11", b32.ALU_result1_OUT, 32'h1);

    alu("and", AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000);
    alu("or", OR_, 32'hF0F0_0000, 32'h0000_0F0F, 0, 32'hF0F0_0F0F);
    alu("slt_neg", SLT, 32'hFFFF_FFFF, 1, 0, 1);
    alu("slt_pos", SLT, 1, 32'hFFFF_FFFF, 0, 0);
    alu("sll31", SLL, 0, 1, 31, 32'h8000_0000);
    alu("srl31", SRL, 0, 32'h8000_0000, 31, 1);
    alu("sra4", SRA, 0, 32'h8000_0000, 4, 32'hF800_0000);
    alu("unknown_op", 6'h05, 32'h1234, 32'h5678, 0, 0);

    // Valid_IN low loads a bubble.
    drv(ADD, 1, 2, 0, 2'b00, 2'b00);
    b32.Valid_IN = 0;
    cyc();
    check("bubble_valid", b32.Valid_OUT, 0);
    check("bubble_result", b32.ALU_result1_OUT, 0);
    check("bubble_regwrite", b32.RegWrite1_OUT, 0);

    // MTHI / MTLO then read back.
    drv(MTHI, 32'h1234, 0, 0, 2'b00, 2'b00);
    cyc();
    mf_read("mthi_mfhi", MFHI, 32'h1234, n);
    drv(MTLO, 0, 0, 0, 2'b10, 2'b00);
    b32.RegWrite_MEMWB = 32'hCAFE;
    cyc();
    mf_read("mtlo_mflo", MFLO, 32'hCAFE, n);

    // Signed multiply -3 * 5; MFHI stalls for the full 32 iterations.
    drv(MULT, 32'hFFFF_FFFD, 5, 0, 2'b00, 2'b00);
    #1 check("mult_stall", b32.Stall_OUT, 0);
    cyc();
    check("mult_result", b32.ALU_result1_OUT, 0);
    check("mult_valid", b32.Valid_OUT, 1);
    check("mult_regwrite", b32.RegWrite1_OUT, 1);
    check("mult_busy", b32.Busy_OUT, 1);
    mf_read("mult_mfhi", MFHI, 32'hFFFF_FFFF, n);
    check("mult_stall_cycles", 64'(n), 32);
    mf_read("mult_mflo", MFLO, 32'hFFFF_FFF1, n);
    check("mult_mflo_nostall", 64'(n), 0);

    // Signed divide 7 / -2, with a stalled-cycle bubble check.
    drv(DIV, 7, 32'hFFFF_FFFE, 0, 2'b00, 2'b00);
    cyc();
    drv(MFLO, 0, 0, 0, 2'b00, 2'b00);
    #1 check("div_mflo_stall", b32.Stall_OUT, 1);
    cyc();
    check("stall_bubble_valid", b32.Valid_OUT, 0);
    check("stall_bubble_regwrite", b32.RegWrite1_OUT, 0);
    mf_read("div_lo", MFLO, 32'hFFFF_FFFD, n);
    mf_read("div_hi", MFHI, 32'h1, n);
    // Negative dividend: remainder follows the dividend sign.
    drv(DIV, 32'hFFFF_FFF9, 2, 0, 2'b00, 2'b00);
    cyc();
    mf_read("divneg_lo", MFLO, 32'hFFFF_FFFD, n);
    mf_read("divneg_hi", MFHI, 32'hFFFF_FFFF, n);
    // Divide by zero, unsigned and signed.
    drv(DIVU, 9, 0, 0, 2'b00, 2'b00);
    cyc();
    mf_read("divu0_lo", MFLO, 32'hFFFF_FFFF, n);
    mf_read("divu0_hi", MFHI, 32'h9, n);
    drv(DIV, 32'hFFFF_FFF8, 0, 0, 2'b00, 2'b00);
    cyc();
    mf_read("div0_lo", MFLO, 32'hFFFF_FFFF, n);
    mf_read("div0_hi", MFHI, 32'hFFFF_FFF8, n);

    // MULTU, then ADD and a store proceed while busy.
    drv(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 2'b00);
    cyc();
    drv(ADD, 2, 3, 0, 2'b00, 2'b00);
    #1 check("busy_add_stall", b32.Stall_OUT, 0);
    cyc();
    check("busy_add", b32.ALU_result1_OUT, 5);
    check("busy_add_valid", b32.Valid_OUT, 1);
    drv(ADD, 32'h100, 4, 0, 2'b00, 2'b01);
    b32.RegWrite_EXEMEM = 32'h55;
    b32.RegWrite1_IN = 0; b32.MemWrite1_IN = 1; b32.MemWriteData1_IN = 32'hDEAD;
    cyc();
    check("sw_addr", b32.ALU_result1_OUT, 32'h155);
    check("sw_wdata", b32.MemWriteData1_OUT, 32'hDEAD);
    check("sw_memwrite", b32.MemWrite1_OUT, 1);
    check("sw_regwrite", b32.RegWrite1_OUT, 0);
    check("sw_busy", b32.Busy_OUT, 1);
    mf_read("multu_hi", MFHI, 32'hFFFF_FFFE, n);
    mf_read("multu_lo", MFLO, 32'h0000_0001, n);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    drv(DIV, 100, 7, 0, 2'b00, 2'b00);
    cyc();
    drv(MFHI, 0, 0, 0, 2'b00, 2'b00);
    repeat (10) cyc();
    #2 RESET = 1'b0;
    #1;
    check("abort_busy", b32.Busy_OUT, 0);
    check("abort_valid", b32.Valid_OUT, 0);
    check("abort_result", b32.ALU_result1_OUT, 0);
    check("abort_stall", b32.Stall_OUT, 0);
    cyc();
    #2 RESET = 1'b1;
    mf_read("abort_mflo", MFLO, 0, n);
    mf_read("abort_mfhi", MFHI, 0, n);

    // 16-bit instance: wrap-around add and 0x8000 * 0x8000.
    idle_all();
    b16.Valid_IN = 1; b16.ALU_Control1_IN = ADD;
    b16.OperandA1_IN = 16'hFFFF; b16.OperandB1_IN = 16'h0002; b16.RegWrite1_IN = 1;
    cyc();
    check("w16_add_wrap", b16.ALU_result1_OUT, 16'h0001);
    b16.ALU_Control1_IN = MULT;
    b16.OperandA1_IN = 16'h8000; b16.OperandB1_IN = 16'h8000;
    cyc();
    b16.Valid_IN = 0;
    n = 0;
    while (b16.Busy_OUT && n < 100) begin
      cyc();
      n++;
    end
    check("w16_busy_cycles", 64'(n), 16);
    b16.Valid_IN = 1; b16.ALU_Control1_IN = MFHI;
    cyc();
    check("w16_mfhi", b16.ALU_result1_OUT, 16'h4000);
    b16.ALU_Control1_IN = MFLO;
    cyc();
    check("w16_mflo", b16.ALU_result1_OUT, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
